snes_pad_tx: RTL

Controller-port serial responder that sits between the controller connector and the console's serial-data input, the `CONTDOUT` pin. It answers the console's latch/clock polling with a 16-bit button word, which is either the real pad's data passed through, a fully injected word, or the real data merged with injected presses. It is the transmit counterpart of `snes_igr`, which only listens on the same bus. It runs on the master clock and feeds OSD/IGR-driven input injection.

---
 rtl/snes_pad_pkg.sv | 45 ++++
 rtl/snes_pad_sync.sv | 33 +++
 rtl/snes_pad_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/snes_pad_pkg.sv
// Shared types for the SNES controller-port responder.
// Mode, FSM encoding, button bit positions and the data-out mux.
package snes_pad_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INJECT = 2'd1,
        MODE_MERGE  = 2'd2,
        MODE_MUTE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DN    = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    // Wire level is active-low; inj is 1 = pressed.
    function automatic logic sdata_mux(mode_e m, logic pad, logic inj);
        logic r;
        r = 1'b1;
        unique case (m)
            MODE_PASS:   r = pad;
            MODE_INJECT: r = ~inj;
            MODE_MERGE:  r = pad & ~inj;
            MODE_MUTE:   r = 1'b1;
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snes_pad_sync.sv
// Multi-flop synchronizer for an asynchronous pad-bus line.
// Emits one-cycle rise/fall pulses from the synchronized level.
module snes_pad_sync #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last_q;
    logic              lvl;

    assign lvl = chain[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= {STAGES{IDLE}};
            last_q <= IDLE;
        end else begin
            chain  <= (chain << 1) | STAGES'(d);
            last_q <= lvl;
        end
    end

    assign rise = lvl & ~last_q;
    assign fall = ~lvl & last_q;

endmodule

// File: rtl/snes_pad_tx.sv
// SNES controller-port responder: serves pass-through, injected
// or merged button words on the console's latch/clock polling.
module snes_pad_tx
    import snes_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NBITS       = 16
) (
    input  logic        CLK_i,
    input  logic        RST_i,
    input  logic        CTRL_LATCH_i,
    input  logic        CTRL_CLK_i,
    input  logic        CTRL_SDATA_i,
    output logic        CTRL_SDATA_o,
    input  logic [1:0]  mode_i,
    input  logic [15:0] inj_word_i,
    output logic        frame_done_o,
    output logic        busy_o
);

    logic lat_rise, lat_fall;
    logic clk_rise, clk_fall;

    snes_pad_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_lat_sync (
        .clk  (CLK_i),
        .rst  (RST_i),
        .d    (CTRL_LATCH_i),
        .rise (lat_rise),
        .fall (lat_fall)
    );

    snes_pad_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_clk_sync (
        .clk  (CLK_i),
        .rst  (RST_i),
        .d    (CTRL_CLK_i),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    state_e      state_q, state_d;
    mode_e       mode_q;
    logic [15:0] shreg_q;
    logic [4:0]  bitcnt_q;
    logic        out_q;
    logic        done_q;
    logic        last_bit;
    logic        load_en;
    logic        shift_en;
    logic        done_hit;
    logic        busy;

    assign last_bit = (bitcnt_q == 5'(NBITS - 1));

    always_ff @(posedge CLK_i) begin
        if (RST_i) state_q <= ST_DONE;
        else       state_q <= state_d;
    end

    // Latch rise outranks everything, including a same-cycle clock edge.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            lat_rise:
                state_d = ST_LOAD;
            !lat_rise && state_q == ST_LOAD && lat_fall:
                state_d = ST_SHIFT;
            !lat_rise && state_q == ST_SHIFT && clk_rise && last_bit:
                state_d = ST_DONE;
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_SHIFT);
        load_en  = lat_rise || (state_q == ST_LOAD);
        shift_en = !lat_rise && (state_q == ST_SHIFT) && clk_rise;
        done_hit = shift_en && last_bit;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            mode_q   <= MODE_PASS;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            out_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_hit;
            if (lat_rise) mode_q <= mode_e'(mode_i);
            if (load_en) begin
                shreg_q  <= inj_word_i;
                bitcnt_q <= '0;
            end else if (shift_en) begin
                shreg_q <= {1'b0, shreg_q[15:1]};
                if (bitcnt_q != 5'(NBITS)) bitcnt_q <= bitcnt_q + 5'd1;
            end else if (state_q == ST_DONE) begin
                shreg_q <= '0;
            end
            out_q <= sdata_mux(mode_q, CTRL_SDATA_i, shreg_q[0]);
        end
    end

    // PASS bypasses the register so real pad timing is untouched.
    assign CTRL_SDATA_o = (mode_q == MODE_PASS) ? CTRL_SDATA_i : out_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy;

    logic unused_ok;
    assign unused_ok = clk_fall;

endmodule
